// File: rtl/writeback_unit_if.sv
// Writeback bundle: execute handshake, memory response, decode hazard query, register-file write port.
// Latency: n/a (wires only).
// Backpressure: ex_ready from the writeback side stalls execute; the memory response cannot be stalled.
// Ports (signals): ex_valid/ex_ready/ex_is_load/ex_funct3/ex_addr_lsb/ex_rd_addr/ex_result,
//   mem_rvalid/mem_rdata, rs1_addr/rs2_addr/hazard, w_en/rd_addr/rd_write_data, load_err.
interface writeback_unit_if #(
  parameter int RF_ADDR_LEN = 5,
  parameter int RF_DATA_LEN = 32
);
  logic                   ex_valid;
  logic                   ex_ready;
  logic                   ex_is_load;
  logic [2:0]             ex_funct3;
  logic [1:0]             ex_addr_lsb;
  logic [RF_ADDR_LEN-1:0] ex_rd_addr;
  logic [RF_DATA_LEN-1:0] ex_result;
  logic                   mem_rvalid;
  logic [RF_DATA_LEN-1:0] mem_rdata;
  logic [RF_ADDR_LEN-1:0] rs1_addr;
  logic [RF_ADDR_LEN-1:0] rs2_addr;
  logic                   hazard;
  logic                   w_en;
  logic [RF_ADDR_LEN-1:0] rd_addr;
  logic [RF_DATA_LEN-1:0] rd_write_data;
  logic                   load_err;

  // Driven by execute/memory/decode (the environment).
  modport master (
    output ex_valid, ex_is_load, ex_funct3, ex_addr_lsb, ex_rd_addr, ex_result,
    output mem_rvalid, mem_rdata, rs1_addr, rs2_addr,
    input  ex_ready, hazard, w_en, rd_addr, rd_write_data, load_err
  );

  // The writeback unit itself.
  modport slave (
    input  ex_valid, ex_is_load, ex_funct3, ex_addr_lsb, ex_rd_addr, ex_result,
    input  mem_rvalid, mem_rdata, rs1_addr, rs2_addr,
    output ex_ready, hazard, w_en, rd_addr, rd_write_data, load_err
  );
endinterface

// File: rtl/writeback_unit.sv
// Writeback stage: registers ALU results, waits for one load response and extends it, flags RAW hazards.
// Latency: 1 cycle ex_valid->w_en for ALU ops; 1 cycle mem_rvalid->w_en for loads.
// Backpressure: ex_ready is low for the whole load wait; a silent memory aborts after LOAD_TIMEOUT cycles.
// Ports: clk, rst (async active-high), wb (slave side of writeback_unit_if).
module writeback_unit #(
  parameter int RF_ADDR_LEN  = 5,
  parameter int RF_DATA_LEN  = 32,
  parameter int LOAD_TIMEOUT = 16
) (
  input logic             clk,
  input logic             rst,
  writeback_unit_if.slave wb
);
  localparam int CNT_W = $clog2(LOAD_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_TIMEOUT - 1);

  typedef enum logic {IDLE, WAIT_LOAD} state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [RF_ADDR_LEN-1:0] pend_rd;
  logic [2:0]             pend_funct3;
  logic [1:0]             pend_lsb;

  logic                   load_ok;
  logic [7:0]             ld_byte;
  logic [15:0]            ld_half;
  logic [RF_DATA_LEN-1:0] ld_value;
  logic                   haz1;
  logic                   haz2;

  assign wb.ex_ready = (state == IDLE);

  // Load legality: unknown funct3 or a misaligned half/word is rejected at accept time.
  always_comb begin
    load_ok = 1'b0;
    case (wb.ex_funct3)
      3'd0, 3'd4: load_ok = 1'b1;
      3'd1, 3'd5: load_ok = ~wb.ex_addr_lsb[0];
      3'd2:       load_ok = (wb.ex_addr_lsb == 2'd0);
      default:    load_ok = 1'b0;
    endcase
  end

  // Pick the addressed byte/half out of the aligned word, then extend by load type.
  always_comb begin
    ld_byte = 8'h00;
    case (pend_lsb)
      2'd0:    ld_byte = wb.mem_rdata[7:0];
      2'd1:    ld_byte = wb.mem_rdata[15:8];
      2'd2:    ld_byte = wb.mem_rdata[23:16];
      default: ld_byte = wb.mem_rdata[31:24];
    endcase
    ld_half = pend_lsb[1] ? wb.mem_rdata[31:16] : wb.mem_rdata[15:0];
    ld_value = wb.mem_rdata;
    case (pend_funct3)
      3'd0:    ld_value = {{(RF_DATA_LEN-8){ld_byte[7]}}, ld_byte};
      3'd1:    ld_value = {{(RF_DATA_LEN-16){ld_half[15]}}, ld_half};
      3'd4:    ld_value = {{(RF_DATA_LEN-8){1'b0}}, ld_byte};
      3'd5:    ld_value = {{(RF_DATA_LEN-16){1'b0}}, ld_half};
      default: ld_value = wb.mem_rdata;
    endcase
  end

  // Hazard covers both the register still owed by a pending load and the one
  // being written this cycle (the register file has not absorbed it yet).
  assign haz1 = (wb.rs1_addr != '0) &&
                (((state == WAIT_LOAD) && (wb.rs1_addr == pend_rd)) ||
                 (wb.w_en && (wb.rs1_addr == wb.rd_addr)));
  assign haz2 = (wb.rs2_addr != '0) &&
                (((state == WAIT_LOAD) && (wb.rs2_addr == pend_rd)) ||
                 (wb.w_en && (wb.rs2_addr == wb.rd_addr)));
  assign wb.hazard = haz1 | haz2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      pend_rd          <= '0;
      pend_funct3      <= '0;
      pend_lsb         <= '0;
      wb.w_en          <= 1'b0;
      wb.rd_addr       <= '0;
      wb.rd_write_data <= '0;
      wb.load_err      <= 1'b0;
    end else begin
      // Writes and errors are single-cycle pulses.
      wb.w_en     <= 1'b0;
      wb.load_err <= 1'b0;
      case (state)
        IDLE: begin
          if (wb.ex_valid) begin
            if (!wb.ex_is_load) begin
              wb.w_en          <= (wb.ex_rd_addr != '0);
              wb.rd_addr       <= wb.ex_rd_addr;
              wb.rd_write_data <= wb.ex_result;
            end else if (load_ok) begin
              pend_rd     <= wb.ex_rd_addr;
              pend_funct3 <= wb.ex_funct3;
              pend_lsb    <= wb.ex_addr_lsb;
              cnt         <= '0;
              state       <= WAIT_LOAD;
            end else begin
              wb.load_err <= 1'b1;
            end
          end
        end
        WAIT_LOAD: begin
          // A response arriving on the expiry cycle still completes the load.
          if (wb.mem_rvalid) begin
            wb.w_en          <= (pend_rd != '0);
            wb.rd_addr       <= pend_rd;
            wb.rd_write_data <= ld_value;
            state            <= IDLE;
          end else if (cnt == CNT_LAST) begin
            wb.load_err <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: ALU writes, load extension, timeout, illegal loads, hazards, reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_writeback_unit;
  localparam int T = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  writeback_unit_if #(.RF_ADDR_LEN(5), .RF_DATA_LEN(32)) wb ();

  writeback_unit #(.RF_ADDR_LEN(5), .RF_DATA_LEN(32), .LOAD_TIMEOUT(T)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic is_load, input logic [2:0] f3, input logic [1:0] lsb,
                       input logic [4:0] rd, input logic [31:0] res);
    wb.ex_valid    = 1'b1;
    wb.ex_is_load  = is_load;
    wb.ex_funct3   = f3;
    wb.ex_addr_lsb = lsb;
    wb.ex_rd_addr  = rd;
    wb.ex_result   = res;
    tick();
    wb.ex_valid    = 1'b0;
  endtask

  // Accept a load, hold the response off for 'dly' cycles, then deliver it.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [1:0] lsb,
                         input logic [4:0] rd, input int dly, input logic [31:0] rdata,
                         input logic [31:0] exp);
    issue(1'b1, f3, lsb, rd, 32'hDEAD_BEEF);
    for (int i = 0; i < dly; i++) begin
      chk({tag, ".rdy_wait"}, {31'b0, wb.ex_ready}, 32'd0);
      tick();
    end
    chk({tag, ".wen_wait"}, {31'b0, wb.w_en}, 32'd0);
    wb.mem_rvalid = 1'b1;
    wb.mem_rdata  = rdata;
    tick();
    wb.mem_rvalid = 1'b0;
    wb.mem_rdata  = 32'h0;
    chk({tag, ".wen"},  {31'b0, wb.w_en}, {31'b0, (rd != 5'd0)});
    if (rd != 5'd0) begin
      chk({tag, ".rd"},   {27'b0, wb.rd_addr}, {27'b0, rd});
      chk({tag, ".data"}, wb.rd_write_data, exp);
    end
    chk({tag, ".err"}, {31'b0, wb.load_err}, 32'd0);
    chk({tag, ".rdy"}, {31'b0, wb.ex_ready}, 32'd1);
  endtask

  task automatic bad_load(input string tag, input logic [2:0] f3, input logic [1:0] lsb);
    issue(1'b1, f3, lsb, 5'd6, 32'h0);
    chk({tag, ".err"}, {31'b0, wb.load_err}, 32'd1);
    chk({tag, ".wen"}, {31'b0, wb.w_en}, 32'd0);
    chk({tag, ".rdy"}, {31'b0, wb.ex_ready}, 32'd1);
    tick();
    chk({tag, ".err_clr"}, {31'b0, wb.load_err}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    wb.ex_valid = 1'b0; wb.ex_is_load = 1'b0; wb.ex_funct3 = 3'd0; wb.ex_addr_lsb = 2'd0;
    wb.ex_rd_addr = 5'd0; wb.ex_result = 32'h0; wb.mem_rvalid = 1'b0; wb.mem_rdata = 32'h0;
    wb.rs1_addr = 5'd0; wb.rs2_addr = 5'd0;
    tick(); tick();
    chk("rst.wen",  {31'b0, wb.w_en}, 32'd0);
    chk("rst.rd",   {27'b0, wb.rd_addr}, 32'd0);
    chk("rst.data", wb.rd_write_data, 32'd0);
    chk("rst.err",  {31'b0, wb.load_err}, 32'd0);
    rst = 1'b0;
    tick();
    chk("idle.rdy", {31'b0, wb.ex_ready}, 32'd1);
    chk("idle.haz", {31'b0, wb.hazard}, 32'd0);

    // ALU write, single-cycle pulse
    issue(1'b0, 3'd0, 2'd0, 5'd5, 32'h1234_5678);
    chk("alu.wen",  {31'b0, wb.w_en}, 32'd1);
    chk("alu.rd",   {27'b0, wb.rd_addr}, 32'd5);
    chk("alu.data", wb.rd_write_data, 32'h1234_5678);
    tick();
    chk("alu.wen_off", {31'b0, wb.w_en}, 32'd0);

    // Load extraction/extension from 0x80FF_0011
    do_load("lb3",  3'd0, 2'd3, 5'd10, 4, 32'h80FF_0011, 32'hFFFF_FF80);
    do_load("lbu3", 3'd4, 2'd3, 5'd11, 4, 32'h80FF_0011, 32'h0000_0080);
    do_load("lhu2", 3'd5, 2'd2, 5'd12, 4, 32'h80FF_0011, 32'h0000_80FF);
    do_load("lh2",  3'd1, 2'd2, 5'd13, 1, 32'h80FF_0011, 32'hFFFF_80FF);
    do_load("lh0",  3'd1, 2'd0, 5'd14, 0, 32'h80FF_0011, 32'h0000_0011);
    do_load("lb2",  3'd0, 2'd2, 5'd15, 2, 32'h80FF_0011, 32'hFFFF_FFFF);
    do_load("lb1",  3'd0, 2'd1, 5'd16, 2, 32'h80FF_0011, 32'h0000_0000);
    do_load("lw",   3'd2, 2'd0, 5'd17, 3, 32'h80FF_0011, 32'h80FF_0011);
    do_load("lw_x0", 3'd2, 2'd0, 5'd0, 3, 32'hCAFE_F00D, 32'h0);
    // Response on the final cycle before expiry wins over the timeout
    do_load("lw_last", 3'd2, 2'd0, 5'd7, T-1, 32'h0BAD_CAFE, 32'h0BAD_CAFE);

    // Timeout: error exactly T cycles after accept, no write
    issue(1'b1, 3'd2, 2'd0, 5'd7, 32'h0);
    for (int i = 0; i < T-1; i++) begin
      chk("to.err_wait", {31'b0, wb.load_err}, 32'd0);
      tick();
    end
    chk("to.rdy_wait", {31'b0, wb.ex_ready}, 32'd0);
    chk("to.err_early", {31'b0, wb.load_err}, 32'd0);
    tick();
    chk("to.err",  {31'b0, wb.load_err}, 32'd1);
    chk("to.wen",  {31'b0, wb.w_en}, 32'd0);
    chk("to.rdy",  {31'b0, wb.ex_ready}, 32'd1);
    tick();
    chk("to.err_clr", {31'b0, wb.load_err}, 32'd0);

    // Illegal / misaligned loads
    bad_load("lh_mis", 3'd1, 2'd1);
    bad_load("f3_3",   3'd3, 2'd0);
    bad_load("lw_mis", 3'd2, 2'd2);
    bad_load("f3_7",   3'd7, 2'd0);

    // ALU to x0 never writes
    issue(1'b0, 3'd0, 2'd0, 5'd0, 32'hFFFF_FFFF);
    chk("alu_x0.wen", {31'b0, wb.w_en}, 32'd0);

    // Stray memory response while idle
    wb.mem_rvalid = 1'b1; wb.mem_rdata = 32'h5555_AAAA;
    tick();
    wb.mem_rvalid = 1'b0;
    chk("stray.wen", {31'b0, wb.w_en}, 32'd0);
    chk("stray.err", {31'b0, wb.load_err}, 32'd0);

    // Hazards against a pending load
    issue(1'b1, 3'd2, 2'd0, 5'd9, 32'h0);
    wb.rs1_addr = 5'd9; #1;
    chk("haz.rs1_pend", {31'b0, wb.hazard}, 32'd1);
    wb.rs1_addr = 5'd8; wb.rs2_addr = 5'd9; #1;
    chk("haz.rs2_pend", {31'b0, wb.hazard}, 32'd1);
    wb.rs2_addr = 5'd0; #1;
    chk("haz.none", {31'b0, wb.hazard}, 32'd0);
    wb.rs1_addr = 5'd0;
    wb.mem_rvalid = 1'b1; wb.mem_rdata = 32'h1;
    tick();
    wb.mem_rvalid = 1'b0;
    tick();
    // Load to x0 pending, rs2=x0: never a hazard
    issue(1'b1, 3'd2, 2'd0, 5'd0, 32'h0);
    #1;
    chk("haz.x0", {31'b0, wb.hazard}, 32'd0);
    wb.mem_rvalid = 1'b1;
    tick();
    wb.mem_rvalid = 1'b0;
    // Hazard during the ALU write cycle only
    issue(1'b0, 3'd0, 2'd0, 5'd4, 32'h44);
    wb.rs2_addr = 5'd4; #1;
    chk("haz.wr", {31'b0, wb.hazard}, 32'd1);
    tick();
    chk("haz.wr_done", {31'b0, wb.hazard}, 32'd0);
    wb.rs2_addr = 5'd0;

    // Reset in the middle of a load
    do_load("pre", 3'd2, 2'd0, 5'd3, 0, 32'h7777_7777, 32'h7777_7777);
    issue(1'b1, 3'd2, 2'd0, 5'd7, 32'h0);
    tick();
    wb.rs1_addr = 5'd7;
    rst = 1'b1; #1;
    chk("mrst.wen",  {31'b0, wb.w_en}, 32'd0);
    chk("mrst.rd",   {27'b0, wb.rd_addr}, 32'd0);
    chk("mrst.data", wb.rd_write_data, 32'd0);
    chk("mrst.rdy",  {31'b0, wb.ex_ready}, 32'd1);
    chk("mrst.haz",  {31'b0, wb.hazard}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    wb.mem_rvalid = 1'b1; wb.mem_rdata = 32'h9999_9999;
    tick();
    wb.mem_rvalid = 1'b0;
    chk("mrst.late_wen", {31'b0, wb.w_en}, 32'd0);
    chk("mrst.late_err", {31'b0, wb.load_err}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
